// File: rtl/gps_tracker_mc.sv
`default_nettype none
// ============================================================================
// Module   : gps_tracker_mc
// Purpose  : Multi-channel GPS/beacon lock tracker with per-channel
//            confirm counting, timeout and hold-over states.
// Revision : 1.0 - initial release
// ============================================================================
module gps_tracker_mc #(
    parameter int CH      = 4,
    parameter int CONFIRM = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] in_ch,
    input  logic [1:0]                           in_code,
    output logic [CH-1:0]                        gps_lock,
    output logic [CH-1:0]                        gps_hold,
    output logic [CH-1:0]                        lost,
    output logic [$clog2(CH+1)-1:0]              lock_count
);

    localparam int c_CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int c_CNT_W = $clog2(CONFIRM + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);
    localparam int c_LC_W  = $clog2(CH + 1);

    localparam logic [c_CNT_W-1:0] c_CONFIRM = c_CNT_W'(CONFIRM);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT = c_TMR_W'(TIMEOUT);

    localparam logic [1:0] c_CODE_PING   = 2'b00;
    localparam logic [1:0] c_CODE_TOGGLE = 2'b01;
    localparam logic [1:0] c_CODE_IDLE   = 2'b10;
    localparam logic [1:0] c_CODE_FIX    = 2'b11;

    typedef enum logic [1:0] {
        ST_BEACON = 2'd0,
        ST_ACQ    = 2'd1,
        ST_GPS    = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t               r_state    [CH];
    logic [c_CNT_W-1:0]   r_cnt      [CH];
    logic [c_TMR_W-1:0]   r_tmr      [CH];

    state_t               w_state_nx [CH];
    logic [c_CNT_W-1:0]   w_cnt_nx   [CH];
    logic [c_TMR_W-1:0]   w_tmr_nx   [CH];
    logic [CH-1:0]        w_hit;
    logic [CH-1:0]        w_lost_nx;
    logic [CH-1:0]        w_lock_nx;
    logic [CH-1:0]        w_hold_nx;
    logic [c_LC_W-1:0]    w_count_nx;

    // Out-of-range in_ch never matches any channel index, so it is dropped here.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < CH; i++) begin
            w_hit[i] = in_valid && (in_ch == c_CH_W'(i));
        end
    end

    always_comb begin
        w_lost_nx = '0;
        for (int i = 0; i < CH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_tmr_nx[i]   = r_tmr[i];
            unique case (r_state[i])
                ST_BEACON: begin
                    if (w_hit[i] && in_code == c_CODE_TOGGLE) begin
                        w_state_nx[i] = ST_ACQ;
                        w_cnt_nx[i]   = '0;
                    end
                end
                ST_ACQ: begin
                    if (w_hit[i]) begin
                        if (in_code == c_CODE_FIX) begin
                            if (r_cnt[i] + c_CNT_W'(1) == c_CONFIRM) begin
                                w_state_nx[i] = ST_GPS;
                                w_cnt_nx[i]   = '0;
                                w_tmr_nx[i]   = '0;
                            end else begin
                                w_cnt_nx[i] = r_cnt[i] + c_CNT_W'(1);
                            end
                        end else if (in_code != c_CODE_IDLE) begin
                            w_state_nx[i] = ST_BEACON;
                            w_cnt_nx[i]   = '0;
                        end
                    end
                end
                ST_GPS: begin
                    // A sample for this channel takes priority over expiry.
                    if (w_hit[i] && in_code == c_CODE_FIX) begin
                        w_tmr_nx[i] = '0;
                    end else if (w_hit[i] && in_code == c_CODE_TOGGLE) begin
                        w_state_nx[i] = ST_BEACON;
                        w_tmr_nx[i]   = '0;
                    end else if (r_tmr[i] + c_TMR_W'(1) == c_TIMEOUT) begin
                        w_state_nx[i] = ST_HOLD;
                        w_tmr_nx[i]   = '0;
                    end else begin
                        w_tmr_nx[i] = r_tmr[i] + c_TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_hit[i] && in_code == c_CODE_FIX) begin
                        w_state_nx[i] = ST_GPS;
                        w_tmr_nx[i]   = '0;
                    end else if (w_hit[i] && in_code == c_CODE_TOGGLE) begin
                        w_state_nx[i] = ST_BEACON;
                        w_tmr_nx[i]   = '0;
                    end else if (r_tmr[i] + c_TMR_W'(1) == c_TIMEOUT) begin
                        w_state_nx[i] = ST_BEACON;
                        w_tmr_nx[i]   = '0;
                        w_lost_nx[i]  = 1'b1;
                    end else begin
                        w_tmr_nx[i] = r_tmr[i] + c_TMR_W'(1);
                    end
                end
                default: w_state_nx[i] = ST_BEACON;
            endcase
        end
    end

    always_comb begin
        w_lock_nx  = '0;
        w_hold_nx  = '0;
        w_count_nx = '0;
        for (int i = 0; i < CH; i++) begin
            w_lock_nx[i] = (w_state_nx[i] == ST_GPS);
            w_hold_nx[i] = (w_state_nx[i] == ST_HOLD);
            w_count_nx   = w_count_nx + c_LC_W'(w_lock_nx[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= ST_BEACON;
                r_cnt[i]   <= '0;
                r_tmr[i]   <= '0;
            end
            gps_lock   <= '0;
            gps_hold   <= '0;
            lost       <= '0;
            lock_count <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_tmr[i]   <= w_tmr_nx[i];
            end
            gps_lock   <= w_lock_nx;
            gps_hold   <= w_hold_nx;
            lost       <= w_lost_nx;
            lock_count <= w_count_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gps_tracker_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_gps_tracker_mc
// Purpose  : Directed self-checking bench for gps_tracker_mc (CH=4 and CH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gps_tracker_mc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [1:0] in_code;
    logic [3:0] gps_lock, gps_hold, lost;
    logic [2:0] lock_count;
    logic [2:0] gps_lock3, gps_hold3, lost3;
    logic [1:0] lock_count3;

    int n_pass;
    int n_total;

    gps_tracker_mc #(.CH(4), .CONFIRM(3), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_code(in_code),
        .gps_lock(gps_lock), .gps_hold(gps_hold), .lost(lost), .lock_count(lock_count)
    );

    gps_tracker_mc #(.CH(3), .CONFIRM(3), .TIMEOUT(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_code(in_code),
        .gps_lock(gps_lock3), .gps_hold(gps_hold3), .lost(lost3), .lock_count(lock_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after an edge; outputs are sampled there too.
    task automatic step(input logic v, input logic [1:0] ch, input logic [1:0] code);
        in_valid = v;
        in_ch    = ch;
        in_code  = code;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 2'b10);
    endtask

    task automatic lock_ch(input logic [1:0] ch);
        step(1'b1, ch, 2'b01);
        step(1'b1, ch, 2'b11);
        step(1'b1, ch, 2'b11);
        step(1'b1, ch, 2'b11);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(2);
        n_total++;
        if ({gps_lock, gps_hold, lost, lock_count} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0", {gps_lock, gps_hold, lost, lock_count});
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        lock_ch(2'd0);
        step(1'b1, 2'd1, 2'b01);
        step(1'b1, 2'd1, 2'b11);
        step(1'b1, 2'd1, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0001 || lock_count !== 3'd1)
            $display("FAIL mid_pre_reset: got lock=%b cnt=%0d expected lock=0001 cnt=1", gps_lock, lock_count);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({gps_lock, gps_hold, lost, lock_count} !== 15'd0)
            $display("FAIL mid_async_reset: got %h expected 0", {gps_lock, gps_hold, lost, lock_count});
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 2'd1, 2'b11);
        step(1'b1, 2'd0, 2'b11);
        step(1'b1, 2'd0, 2'b11);
        step(1'b1, 2'd0, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0000)
            $display("FAIL mid_no_stale_lock: got %b expected 0000", gps_lock);
        else n_pass++;
        step(1'b1, 2'd0, 2'b01);
        step(1'b1, 2'd0, 2'b11);
        step(1'b1, 2'd0, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0000)
            $display("FAIL mid_relock_early: got %b expected 0000", gps_lock);
        else n_pass++;
        step(1'b1, 2'd0, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0001)
            $display("FAIL mid_relock: got %b expected 0001", gps_lock);
        else n_pass++;
    endtask

    task automatic test_acquisition();
        do_reset();
        step(1'b1, 2'd2, 2'b01);
        step(1'b1, 2'd2, 2'b11);
        step(1'b1, 2'd2, 2'b10);
        step(1'b1, 2'd2, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0000 || lock_count !== 3'd0)
            $display("FAIL acq_two_fixes: got lock=%b cnt=%0d expected 0000/0", gps_lock, lock_count);
        else n_pass++;
        step(1'b1, 2'd2, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0100 || lock_count !== 3'd1)
            $display("FAIL acq_lock: got lock=%b cnt=%0d expected 0100/1", gps_lock, lock_count);
        else n_pass++;
        step(1'b1, 2'd0, 2'b01);
        step(1'b1, 2'd0, 2'b11);
        step(1'b1, 2'd0, 2'b00);
        step(1'b1, 2'd0, 2'b11);
        step(1'b1, 2'd0, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0100 || gps_hold !== 4'b0000)
            $display("FAIL acq_abort: got lock=%b hold=%b expected 0100/0000", gps_lock, gps_hold);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        lock_ch(2'd1);
        idle(7);
        n_total++;
        if (gps_lock !== 4'b0010 || gps_hold !== 4'b0000)
            $display("FAIL to_gps_7: got lock=%b hold=%b expected 0010/0000", gps_lock, gps_hold);
        else n_pass++;
        idle(1);
        n_total++;
        if (gps_lock !== 4'b0000 || gps_hold !== 4'b0010 || lock_count !== 3'd0)
            $display("FAIL to_hold: got lock=%b hold=%b cnt=%0d expected 0000/0010/0", gps_lock, gps_hold, lock_count);
        else n_pass++;
        idle(7);
        n_total++;
        if (gps_hold !== 4'b0010 || lost !== 4'b0000)
            $display("FAIL to_hold_7: got hold=%b lost=%b expected 0010/0000", gps_hold, lost);
        else n_pass++;
        idle(1);
        n_total++;
        if (gps_hold !== 4'b0000 || lost !== 4'b0010)
            $display("FAIL to_lost: got hold=%b lost=%b expected 0000/0010", gps_hold, lost);
        else n_pass++;
        idle(1);
        n_total++;
        if (lost !== 4'b0000)
            $display("FAIL to_lost_pulse: got %b expected 0000", lost);
        else n_pass++;
    endtask

    task automatic test_expiry_race();
        do_reset();
        lock_ch(2'd1);
        idle(8);
        idle(7);
        step(1'b1, 2'd1, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0010 || gps_hold !== 4'b0000 || lost !== 4'b0000)
            $display("FAIL race_hold: got lock=%b hold=%b lost=%b expected 0010/0000/0000", gps_lock, gps_hold, lost);
        else n_pass++;
        idle(7);
        step(1'b1, 2'd1, 2'b11);
        n_total++;
        if (gps_lock !== 4'b0010 || gps_hold !== 4'b0000)
            $display("FAIL race_gps: got lock=%b hold=%b expected 0010/0000", gps_lock, gps_hold);
        else n_pass++;
    endtask

    task automatic test_release_illegal();
        do_reset();
        lock_ch(2'd0);
        n_total++;
        if (gps_lock !== 4'b0001 || gps_lock3 !== 3'b001)
            $display("FAIL rel_lock0: got lock=%b lock3=%b expected 0001/001", gps_lock, gps_lock3);
        else n_pass++;
        lock_ch(2'd3);
        n_total++;
        if (gps_lock3 !== 3'b001 || lock_count3 !== 2'd1 || gps_hold3 !== 3'b000)
            $display("FAIL illegal_ch: got lock3=%b cnt3=%0d hold3=%b expected 001/1/000", gps_lock3, lock_count3, gps_hold3);
        else n_pass++;
        n_total++;
        if (gps_lock !== 4'b1001 || lock_count !== 3'd2)
            $display("FAIL legal_ch3: got lock=%b cnt=%0d expected 1001/2", gps_lock, lock_count);
        else n_pass++;
        step(1'b1, 2'd0, 2'b01);
        n_total++;
        if (gps_lock !== 4'b1000 || lock_count !== 3'd1 || lost !== 4'b0000 || gps_hold !== 4'b0000)
            $display("FAIL release: got lock=%b cnt=%0d lost=%b hold=%b expected 1000/1/0000/0000", gps_lock, lock_count, lost, gps_hold);
        else n_pass++;
        n_total++;
        if (gps_lock3 !== 3'b000 || lock_count3 !== 2'd0 || lost3 !== 3'b000)
            $display("FAIL release3: got lock3=%b cnt3=%0d lost3=%b expected 000/0/000", gps_lock3, lock_count3, lost3);
        else n_pass++;
    endtask

    task automatic test_multichannel();
        logic [1:0] order [3];
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd3;
        do_reset();
        for (int j = 0; j < 3; j++) step(1'b1, order[j], 2'b01);
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) step(1'b1, order[j], 2'b11);
        n_total++;
        if (gps_lock !== 4'b1011 || lock_count !== 3'd3)
            $display("FAIL multi_lock: got lock=%b cnt=%0d expected 1011/3", gps_lock, lock_count);
        else n_pass++;
        for (int k = 0; k < 7; k++) step(1'b1, (k % 2 == 0) ? 2'd0 : 2'd3, 2'b11);
        n_total++;
        if (gps_lock !== 4'b1001 || gps_hold !== 4'b0010 || lock_count !== 3'd2)
            $display("FAIL multi_hold: got lock=%b hold=%b cnt=%0d expected 1001/0010/2", gps_lock, gps_hold, lock_count);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_ch    = 2'd0;
        in_code  = 2'b10;
        test_reset();
        test_reset_mid();
        test_acquisition();
        test_timeout();
        test_expiry_race();
        test_release_illegal();
        test_multichannel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gps_tracker_mc.md
# gps_tracker_mc

Multi-channel GPS/beacon lock tracker: the parametrised successor of the two-state beacon/GPS tracker. It keeps an independent 4-state lock FSM per channel, with confirmation counting on acquisition and a signal-loss timeout with a hold-over state. It sits between the time-multiplexed receiver sample stream and the navigation controller, reporting per-channel lock status, loss events and a lock count.

## Interface
- CH, 4, number of tracked channels (≥1)
- CONFIRM, 3, consecutive-qualifying fix samples needed to go ACQ→GPS (≥1)
- TIMEOUT, 8, cycles without refresh before GPS→HOLD and HOLD→BEACON (≥2)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; asynchronous assert, active-low (0 = reset)
- in_valid  input  1  sample strobe; in_ch/in_code are sampled only when 1
- in_ch  input  max(1,$clog2(CH))  channel the sample belongs to; values ≥CH are ignored
- in_code  input  2  00 beacon ping, 01 mode toggle, 10 idle, 11 GPS fix
- gps_lock  output  CH  bit i = channel i in GPS
- gps_hold  output  CH  bit i = channel i in HOLD
- lost  output  CH  bit i pulses 1 cycle when channel i times out HOLD→BEACON
- lock_count  output  $clog2(CH+1)  number of channels currently in GPS

## Operation
- Per-channel state (2 bits): BEACON=0, ACQ=1, GPS=2, HOLD=3. Each channel also has a confirm counter ($clog2(CONFIRM+1) bits) and a timer ($clog2(TIMEOUT+1) bits).
- A "sample for ch i" means in_valid=1 and in_ch=i in that cycle. At most one channel is sampled per cycle.
- BEACON: 01 → ACQ, confirm counter cleared. 00/10/11 → stay.
- ACQ: 11 → counter+1. When the counter reaches CONFIRM, go to GPS and clear the timer. CONFIRM=1 means a single 11 enters GPS. 00 or 01 → BEACON (abort), counter cleared. 10 → stay, counter held.
- GPS: 11 → stay, timer cleared (refresh). 01 → BEACON (release), no lost pulse. 00/10 and no sample → timer+1. When the timer would reach TIMEOUT → HOLD, timer cleared.
- HOLD: 11 → GPS, timer cleared (reacquire). 01 → BEACON, no lost pulse. 00/10 and no sample → timer+1. When the timer would reach TIMEOUT → BEACON with lost[i]=1 for that one cycle.
- Timers count every clock cycle in GPS/HOLD, not only sampled cycles.
- Simultaneous events: a sample for the channel in the same cycle as timer expiry wins. For example, an 11 at expiry keeps GPS, or returns HOLD to GPS, with no lost pulse.
- in_ch ≥ CH: the sample is dropped, with no effect on any channel.
- lock_count is the popcount of the next gps_lock value, registered, so it is always consistent with gps_lock in the same cycle.

## Timing
- Reset (rst=0, asynchronous): all channels BEACON, counters and timers 0, gps_lock=0, gps_hold=0, lost=0, lock_count=0. Applies immediately, including mid-ACQ or mid-timeout. The first transition is possible on the first rising edge after rst returns to 1.
- All outputs are registered. A sample at edge E is reflected in the outputs after E (1-cycle latency).
- GPS→HOLD occurs exactly TIMEOUT edges after the last refresh edge (or after GPS entry) when no 11 arrives.
- HOLD→BEACON occurs exactly TIMEOUT edges after HOLD entry when no 11 or 01 arrives.
- lost[i] is high for exactly one cycle, coincident with gps_hold[i] falling. It is never asserted by a 01 release.
- Channels are fully independent. Activity on one channel never alters another channel's counter or timer.

## Test plan
- Reset mid-operation: ch0 in GPS, ch1 in ACQ with count 2; drive rst=0 between edges → all outputs 0 immediately. After release, ch0 needs a fresh 01 plus three 11 samples to lock.
- Acquisition (CH=4, CONFIRM=3): ch2 receives 01, 11, 10, 11, 11 → gps_lock=0100 only after the third 11, and lock_count=1 in the same cycle. A 00 inserted after the first 11 aborts to BEACON.
- Timeout chain (TIMEOUT=8): ch1 locks, then no samples → gps_hold[1]=1 8 cycles after the last refresh. Then 8 more cycles → gps_hold[1]=0 and lost=0010 for exactly 1 cycle.
- Expiry race: ch1 in HOLD; an 11 for ch1 arrives in the cycle the timer would expire → gps_lock[1]=1, lost[1] stays 0.
- Release and illegal channel: with CH=3, a sample with in_ch=3 has no effect. A 01 for locked ch0 → BEACON, lost=0, lock_count decrements.
- Multi-channel: lock ch0, ch1 and ch3 interleaved cycle by cycle → lock_count=3 and gps_lock=1011. Only ch0 and ch3 receive refreshes → only ch1 enters HOLD.
